// File: rtl/accum_table_rd_ctrl.sv
// ---------------------------------------------------------------------------
// accum_table_rd_ctrl
//   Read-side controller for the accumulator table. A start pulse sweeps all
//   programmed output sub-matrices (sub_row innermost, then sub-matrix row,
//   then sub-matrix column) and issues one read per cycle to every column
//   bank. Returned data lands in a small FIFO, and that FIFO drives a
//   valid/ready stream. Reads are only issued while the FIFO has a reserved
//   slot, so downstream backpressure never drops a beat.
//
// Ports
//   clk, reset          clock, asynchronous active-low reset
//   start               1-cycle start pulse (honoured only in IDLE)
//   row_submats_m1      sub-matrix rows - 1, latched on start
//   col_submats_m1      sub-matrix cols - 1, latched on start
//   busy / done         sweep in progress / 1-cycle completion pulse
//   rd_en_out           per-bank read enable (all bits equal)
//   rd_addr_out         per-bank read address (all slices equal)
//   rd_data_in          per-bank read data, RD_LATENCY cycles after rd_en_out
//   out_valid/out_ready output stream handshake
//   out_data            one row segment across all column banks
//   out_row             global output row of the beat
//   out_col_submat      column sub-matrix index of the beat
//   out_last            final beat of the sweep
// ---------------------------------------------------------------------------
module accum_table_rd_ctrl #(
    parameter int MAX_OUT_ROWS = 128,
    parameter int MAX_OUT_COLS = 128,
    parameter int SYS_ARR_ROWS = 16,
    parameter int SYS_ARR_COLS = 16,
    parameter int DATA_WIDTH   = 32,
    parameter int RD_LATENCY   = 1
) (
    input  logic                                                                   clk,
    input  logic                                                                   reset,
    input  logic                                                                   start,
    input  logic [$clog2(MAX_OUT_ROWS/SYS_ARR_ROWS)-1:0]                           row_submats_m1,
    input  logic [$clog2(MAX_OUT_COLS/SYS_ARR_COLS)-1:0]                           col_submats_m1,
    output logic                                                                   busy,
    output logic                                                                   done,
    output logic [SYS_ARR_COLS-1:0]                                                rd_en_out,
    output logic [$clog2(MAX_OUT_ROWS*(MAX_OUT_COLS/SYS_ARR_COLS))*SYS_ARR_COLS-1:0] rd_addr_out,
    input  logic [DATA_WIDTH*SYS_ARR_COLS-1:0]                                     rd_data_in,
    output logic                                                                   out_valid,
    input  logic                                                                   out_ready,
    output logic [DATA_WIDTH*SYS_ARR_COLS-1:0]                                     out_data,
    output logic [$clog2(MAX_OUT_ROWS)-1:0]                                        out_row,
    output logic [$clog2(MAX_OUT_COLS/SYS_ARR_COLS)-1:0]                           out_col_submat,
    output logic                                                                   out_last
);

    localparam int NUM_ROW_SUB_MAT = MAX_OUT_ROWS / SYS_ARR_ROWS;
    localparam int NUM_COL_SUB_MAT = MAX_OUT_COLS / SYS_ARR_COLS;
    localparam int ADDR_WIDTH      = $clog2(MAX_OUT_ROWS * NUM_COL_SUB_MAT);
    localparam int ROW_W           = $clog2(MAX_OUT_ROWS);
    localparam int RSM_W           = $clog2(NUM_ROW_SUB_MAT);
    localparam int CSM_W           = $clog2(NUM_COL_SUB_MAT);
    localparam int SR_W            = (SYS_ARR_ROWS > 1) ? $clog2(SYS_ARR_ROWS) : 1;
    localparam int FIFO_DEPTH      = RD_LATENCY + 2;
    localparam int PTR_W           = $clog2(FIFO_DEPTH);
    localparam int CNT_W           = $clog2(FIFO_DEPTH + 1);
    localparam int CR_W            = $clog2(2 * FIFO_DEPTH + 2);
    localparam int ROWDATA_W       = DATA_WIDTH * SYS_ARR_COLS;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    // Per-beat tag that travels alongside a read through the latency pipe
    typedef struct packed {
        logic [ROW_W-1:0] row;
        logic [CSM_W-1:0] col;
        logic             last;
    } tag_t;

    state_t                r_state, w_state_nxt;

    logic [RSM_W-1:0]      r_rows_m1, r_cols_m1_unused_guard;
    logic [CSM_W-1:0]      r_cols_m1;
    logic [SR_W-1:0]       r_sub_row;
    logic [RSM_W-1:0]      r_srow;
    logic [CSM_W-1:0]      r_scol;

    logic [RD_LATENCY:0]   r_vld_pipe;
    tag_t                  r_tag_pipe [0:RD_LATENCY];
    logic [ADDR_WIDTH-1:0] r_rd_addr;

    logic [ROWDATA_W-1:0]  r_fifo_data [0:FIFO_DEPTH-1];
    tag_t                  r_fifo_tag  [0:FIFO_DEPTH-1];
    logic [PTR_W-1:0]      r_wr_ptr, r_rd_ptr;
    logic [CNT_W-1:0]      r_count;

    logic [RSM_W-1:0]      w_rows_m1;
    logic [CSM_W-1:0]      w_cols_m1;
    logic [SR_W-1:0]       w_cur_sub_row, w_nxt_sub_row;
    logic [RSM_W-1:0]      w_cur_srow, w_nxt_srow;
    logic [CSM_W-1:0]      w_cur_scol, w_nxt_scol;
    logic                  w_sr_wrap, w_srow_wrap, w_scol_wrap, w_final;
    logic [ROW_W-1:0]      w_row;
    logic [ADDR_WIDTH-1:0] w_addr;
    tag_t                  w_tag, w_head_tag;
    logic                  w_push, w_pop, w_issue, w_credit_ok, w_last_hs;
    logic [CR_W-1:0]       w_outstanding, w_used;

    // Sizes are taken straight from the inputs in the start cycle so the
    // first read can be registered on the same edge that leaves IDLE.
    assign w_rows_m1     = (r_state == S_IDLE) ? row_submats_m1 : r_rows_m1;
    assign w_cols_m1     = (r_state == S_IDLE) ? col_submats_m1 : r_cols_m1;
    assign w_cur_sub_row = (r_state == S_IDLE) ? '0 : r_sub_row;
    assign w_cur_srow    = (r_state == S_IDLE) ? '0 : r_srow;
    assign w_cur_scol    = (r_state == S_IDLE) ? '0 : r_scol;

    assign w_sr_wrap   = (w_cur_sub_row == SR_W'(SYS_ARR_ROWS - 1));
    assign w_srow_wrap = (w_cur_srow == w_rows_m1);
    assign w_scol_wrap = (w_cur_scol == w_cols_m1);
    assign w_final     = w_sr_wrap && w_srow_wrap && w_scol_wrap;

    assign w_row  = ROW_W'(w_cur_srow) * ROW_W'(SYS_ARR_ROWS) + ROW_W'(w_cur_sub_row);
    assign w_addr = ADDR_WIDTH'(w_cur_scol) * ADDR_WIDTH'(MAX_OUT_ROWS) + ADDR_WIDTH'(w_row);

    assign w_tag.row  = w_row;
    assign w_tag.col  = w_cur_scol;
    assign w_tag.last = w_final;

    // Counter advance; the final beat wraps everything back to zero
    always_comb begin
        w_nxt_sub_row = w_cur_sub_row + SR_W'(1);
        w_nxt_srow    = w_cur_srow;
        w_nxt_scol    = w_cur_scol;
        if (w_sr_wrap) begin
            w_nxt_sub_row = '0;
            if (w_srow_wrap) begin
                w_nxt_srow = '0;
                w_nxt_scol = w_scol_wrap ? '0 : (w_cur_scol + CSM_W'(1));
            end else begin
                w_nxt_srow = w_cur_srow + RSM_W'(1);
            end
        end
    end

    // FIFO handshake
    assign w_head_tag = r_fifo_tag[r_rd_ptr];
    assign out_valid  = (r_count != '0);
    assign w_pop      = out_valid && out_ready;
    assign w_push     = r_vld_pipe[RD_LATENCY];
    assign w_last_hs  = w_pop && w_head_tag.last;

    // Credit: every read on the bus or in the latency pipe (including the one
    // returning now) already owns a FIFO slot. A pop this cycle frees a slot
    // for the read being registered now, which keeps one beat per cycle with
    // only RD_LATENCY+2 entries.
    always_comb begin
        w_outstanding = '0;
        for (int k = 0; k <= RD_LATENCY; k++) begin
            w_outstanding = w_outstanding + CR_W'(r_vld_pipe[k]);
        end
        w_used      = CR_W'(r_count) + w_outstanding - CR_W'(w_pop);
        w_credit_ok = (w_used < CR_W'(FIFO_DEPTH));
    end

    // FSM next state / issue decision
    always_comb begin
        w_state_nxt = r_state;
        w_issue     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_issue     = w_credit_ok;
                    w_state_nxt = (w_issue && w_final) ? S_DRAIN : S_READ;
                end
            end
            S_READ: begin
                w_issue = w_credit_ok;
                if (w_issue && w_final) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (w_last_hs && (w_outstanding == '0) && (r_count == CNT_W'(1))) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Sweep counters and latched sizes
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rows_m1 <= '0;
            r_cols_m1 <= '0;
            r_sub_row <= '0;
            r_srow    <= '0;
            r_scol    <= '0;
        end else begin
            if ((r_state == S_IDLE) && start) begin
                r_rows_m1 <= row_submats_m1;
                r_cols_m1 <= col_submats_m1;
                r_sub_row <= '0;
                r_srow    <= '0;
                r_scol    <= '0;
            end
            if (w_issue) begin
                r_sub_row <= w_nxt_sub_row;
                r_srow    <= w_nxt_srow;
                r_scol    <= w_nxt_scol;
            end
        end
    end

    assign r_cols_m1_unused_guard = '0;

    // Read request register and latency pipe. r_vld_pipe[k] marks a read
    // issued k cycles ago; at k == RD_LATENCY its data is on rd_data_in.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_vld_pipe <= '0;
            r_rd_addr  <= '0;
            for (int k = 0; k <= RD_LATENCY; k++) begin
                r_tag_pipe[k] <= '0;
            end
        end else begin
            r_vld_pipe[0] <= w_issue;
            if (w_issue) begin
                r_rd_addr     <= w_addr;
                r_tag_pipe[0] <= w_tag;
            end
            for (int k = 1; k <= RD_LATENCY; k++) begin
                r_vld_pipe[k] <= r_vld_pipe[k-1];
                r_tag_pipe[k] <= r_tag_pipe[k-1];
            end
        end
    end

    assign rd_en_out   = {SYS_ARR_COLS{r_vld_pipe[0]}};
    assign rd_addr_out = {SYS_ARR_COLS{r_rd_addr}};

    // Output FIFO; push and pop on a full FIFO in the same cycle is legal
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int k = 0; k < FIFO_DEPTH; k++) begin
                r_fifo_data[k] <= '0;
                r_fifo_tag[k]  <= '0;
            end
        end else begin
            if (w_push) begin
                r_fifo_data[r_wr_ptr] <= rd_data_in;
                r_fifo_tag[r_wr_ptr]  <= r_tag_pipe[RD_LATENCY];
                r_wr_ptr <= (r_wr_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : (r_wr_ptr + PTR_W'(1));
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : (r_rd_ptr + PTR_W'(1));
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CNT_W'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - CNT_W'(1);
            end
        end
    end

    assign out_data       = r_fifo_data[r_rd_ptr];
    assign out_row        = w_head_tag.row;
    assign out_col_submat = w_head_tag.col;
    assign out_last       = out_valid && w_head_tag.last;

    assign busy = (r_state == S_READ) || (r_state == S_DRAIN);
    assign done = (r_state == S_DONE);

endmodule

// File: tb/tb_accum_table_rd_ctrl.sv
`timescale 1ns/1ps
module tb_accum_table_rd_ctrl;

    localparam int MOR = 128, MOC = 128, SAR = 16, SAC = 16, DW = 32, RDL = 1;
    localparam int NRS = MOR / SAR, NCS = MOC / SAC;
    localparam int AW  = $clog2(MOR * NCS);
    localparam int RW  = $clog2(MOR);
    localparam int RSW = $clog2(NRS);
    localparam int CSW = $clog2(NCS);
    localparam int FD  = RDL + 2;

    logic               clk = 1'b0;
    logic               reset;
    logic               start;
    logic [RSW-1:0]     row_submats_m1;
    logic [CSW-1:0]     col_submats_m1;
    logic               busy, done;
    logic [SAC-1:0]     rd_en_out;
    logic [AW*SAC-1:0]  rd_addr_out;
    logic [DW*SAC-1:0]  rd_data_in;
    logic               out_valid;
    logic               out_ready;
    logic [DW*SAC-1:0]  out_data;
    logic [RW-1:0]      out_row;
    logic [CSW-1:0]     out_col_submat;
    logic               out_last;

    accum_table_rd_ctrl #(
        .MAX_OUT_ROWS(MOR), .MAX_OUT_COLS(MOC), .SYS_ARR_ROWS(SAR),
        .SYS_ARR_COLS(SAC), .DATA_WIDTH(DW), .RD_LATENCY(RDL)
    ) dut (
        .clk(clk), .reset(reset), .start(start),
        .row_submats_m1(row_submats_m1), .col_submats_m1(col_submats_m1),
        .busy(busy), .done(done), .rd_en_out(rd_en_out), .rd_addr_out(rd_addr_out),
        .rd_data_in(rd_data_in), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_row(out_row), .out_col_submat(out_col_submat),
        .out_last(out_last)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW*SAC-1:0] data;
        logic [RW-1:0]     row;
        logic [CSW-1:0]    col;
        logic              last;
    } beat_t;

    beat_t sb_q[$];
    int    checks = 0, errors = 0;
    int    n_issued = 0, n_popped = 0, n_done = 0, n_last = 0;
    int    max_addr = 0, max_out = 0, last_row = -1, last_col = -1;
    bit    saw_275 = 0, saw_row19 = 0;

    function automatic logic [DW-1:0] bank_word(input int a, input int b);
        return 32'(32'h5A00_0000 | (a << 8) | (b << 4) | 5);
    endfunction

    function automatic logic [DW*SAC-1:0] row_data(input int a);
        logic [DW*SAC-1:0] r;
        for (int b = 0; b < SAC; b++) r[b*DW +: DW] = bank_word(a, b);
        return r;
    endfunction

    // Bank model: a read seen in cycle n returns data in cycle n+1; each bank
    // uses its own address slice
    logic              pend_en = 1'b0;
    logic [AW*SAC-1:0] pend_addr = '0;
    always @(posedge clk) begin
        pend_en   <= rd_en_out[0];
        pend_addr <= rd_addr_out;
    end
    always_comb begin
        rd_data_in = '0;
        for (int b = 0; b < SAC; b++)
            rd_data_in[b*DW +: DW] = pend_en ? bank_word(int'(pend_addr[b*AW +: AW]), b) : 32'hDEAD_BEEF;
    end

    // Monitor / scoreboard
    always @(negedge clk) begin
        bit    ok;
        beat_t e;
        if (rd_en_out !== '0) begin
            n_issued++;
            checks++;
            ok = (rd_en_out === '1);
            for (int b = 1; b < SAC; b++)
                if (rd_addr_out[b*AW +: AW] !== rd_addr_out[AW-1:0]) ok = 0;
            if (!ok) begin
                errors++;
                $display("FAIL rd_bus_uniform: en=%h addr0=%0d", rd_en_out, rd_addr_out[AW-1:0]);
            end
            if (int'(rd_addr_out[AW-1:0]) > max_addr) max_addr = int'(rd_addr_out[AW-1:0]);
            if (rd_addr_out[AW-1:0] == AW'(275)) saw_275 = 1;
        end
        if (out_valid === 1'b1 && out_ready === 1'b1) begin
            checks++;
            n_popped++;
            if (out_last) n_last++;
            last_row = int'(out_row);
            last_col = int'(out_col_submat);
            if (out_col_submat == CSW'(2) && out_row == RW'(19) && out_data[DW-1:0] == bank_word(275, 0))
                saw_row19 = 1;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL beat_unexpected: got row=%0d col=%0d, required no beat", out_row, out_col_submat);
            end else begin
                e = sb_q.pop_front();
                if (out_data !== e.data || out_row !== e.row || out_col_submat !== e.col || out_last !== e.last) begin
                    errors++;
                    $display("FAIL beat: got row=%0d col=%0d last=%0b d0=%h, required row=%0d col=%0d last=%0b d0=%h",
                             out_row, out_col_submat, out_last, out_data[DW-1:0], e.row, e.col, e.last, e.data[DW-1:0]);
                end
            end
        end
        if (done === 1'b1) n_done++;
        if (n_issued - n_popped > max_out) max_out = n_issued - n_popped;
    end

    task automatic push_sweep(input int rm1, input int cm1);
        beat_t b;
        for (int sc = 0; sc <= cm1; sc++)
            for (int sr = 0; sr <= rm1; sr++)
                for (int r = 0; r < SAR; r++) begin
                    b.data = row_data(sc * MOR + sr * SAR + r);
                    b.row  = RW'(sr * SAR + r);
                    b.col  = CSW'(sc);
                    b.last = (sc == cm1) && (sr == rm1) && (r == SAR - 1);
                    sb_q.push_back(b);
                end
    endtask

    task automatic pulse_start(input int rm1, input int cm1);
        @(posedge clk); #1;
        start = 1'b1; row_submats_m1 = RSW'(rm1); col_submats_m1 = CSW'(cm1);
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input bit rnd, input string tag);
        bit seen = 0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (done === 1'b1) seen = 1;
            else if (rnd) begin
                @(posedge clk); #1;
                out_ready = ($urandom_range(0, 3) != 0);
            end
        end
        out_ready = 1'b1;
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL %s_timeout: done not seen within %0d cycles, required done", tag, budget);
        end else begin
            @(negedge clk);
            checks++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL %s_done_pulse: done=%b busy=%b one cycle later, required 0 0", tag, done, busy);
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; start = 1'b0; out_ready = 1'b1;
        row_submats_m1 = '0; col_submats_m1 = '0;
        #2;
        checks++;
        if ({busy, done, rd_en_out, out_valid, out_last} !== '0 || rd_addr_out !== '0 ||
            out_data !== '0 || out_row !== '0 || out_col_submat !== '0) begin
            errors++;
            $display("FAIL reset_outputs: busy=%b done=%b en=%h valid=%b last=%b row=%0d, required all 0",
                     busy, done, rd_en_out, out_valid, out_last, out_row);
        end
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
    endtask

    task automatic test_single_submat();
        logic [4:0] got, exp;
        bit         ok;
        push_sweep(0, 0);
        @(posedge clk); #1;
        start = 1'b1; row_submats_m1 = '0; col_submats_m1 = '0;   // cycle 0
        @(posedge clk); #1;
        start = 1'b0;                                               // cycle 1
        for (int k = 1; k <= 20; k++) begin
            if (k > 1) @(posedge clk);
            @(negedge clk);
            exp = {(k >= 1 && k <= 18), (k >= 1 && k <= 16), (k >= 3 && k <= 18), (k == 18), (k == 19)};
            got = {busy, rd_en_out[0], out_valid, out_last, done};
            ok  = (got === exp);
            if (k <= 16 && rd_en_out !== 16'hFFFF) ok = 0;
            if (k <= 16 && rd_addr_out[AW-1:0] !== AW'(k - 1)) ok = 0;
            if (k >= 3 && k <= 18 && out_row !== RW'(k - 3)) ok = 0;
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL single_cycle%0d: {busy,en,valid,last,done}=%b addr=%0d row=%0d, required %b addr=%0d row=%0d",
                         k, got, rd_addr_out[AW-1:0], out_row, exp, k - 1, k - 3);
            end
        end
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL single_leftover: %0d beats pending, required 0", sb_q.size());
        end
    endtask

    task automatic test_full_sweep();
        int p0 = n_popped, l0 = n_last;
        max_addr = 0;
        push_sweep(7, 7);
        pulse_start(7, 7);
        wait_done(2000, 0, "full");
        checks++;
        if (n_popped - p0 != 1024 || n_last - l0 != 1 || max_addr != 1023 || last_row != 127 || last_col != 7) begin
            errors++;
            $display("FAIL full_sweep: beats=%0d lasts=%0d maxaddr=%0d lastrow=%0d lastcol=%0d, required 1024 1 1023 127 7",
                     n_popped - p0, n_last - l0, max_addr, last_row, last_col);
        end
    endtask

    task automatic test_addr_spot();
        int p0 = n_popped;
        saw_275 = 0; saw_row19 = 0;
        push_sweep(2, 2);
        pulse_start(2, 2);
        wait_done(400, 0, "spot");
        checks++;
        if (!saw_275 || !saw_row19 || n_popped - p0 != 144) begin
            errors++;
            $display("FAIL addr_spot: saw_addr275=%0b saw_row19=%0b beats=%0d, required 1 1 144",
                     saw_275, saw_row19, n_popped - p0);
        end
    endtask

    task automatic test_backpressure();
        int p0 = n_popped;
        max_out = 0;
        push_sweep(1, 1);
        pulse_start(1, 1);
        repeat (10) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (20) @(posedge clk);
        @(negedge clk);
        checks++;
        if (n_issued - n_popped != FD || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL bp_stall: outstanding=%0d valid=%b, required %0d 1", n_issued - n_popped, out_valid, FD);
        end
        @(posedge clk); #1 out_ready = 1'b1;
        wait_done(400, 0, "bp");
        checks++;
        if (max_out > FD || n_popped - p0 != 64 || sb_q.size() != 0) begin
            errors++;
            $display("FAIL bp_result: max_outstanding=%0d beats=%0d pending=%0d, required <=%0d 64 0",
                     max_out, n_popped - p0, sb_q.size(), FD);
        end
    endtask

    task automatic test_random_ready();
        int p0 = n_popped;
        max_out = 0;
        push_sweep(2, 1);
        pulse_start(2, 1);
        wait_done(1000, 1, "rnd");
        checks++;
        if (n_popped - p0 != 96 || max_out > FD) begin
            errors++;
            $display("FAIL rnd_result: beats=%0d max_outstanding=%0d, required 96 <=%0d", n_popped - p0, max_out, FD);
        end
    endtask

    task automatic test_start_while_busy();
        int p0 = n_popped, d0 = n_done;
        push_sweep(0, 1);
        pulse_start(0, 1);
        repeat (10) @(posedge clk);
        #1 start = 1'b1; row_submats_m1 = RSW'(7); col_submats_m1 = CSW'(7);
        @(posedge clk); #1 start = 1'b0;
        wait_done(200, 0, "rebusy");
        repeat (5) @(negedge clk);
        checks++;
        if (n_popped - p0 != 32 || n_done - d0 != 1 || busy !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL start_while_busy: beats=%0d dones=%0d busy=%b valid=%b, required 32 1 0 0",
                     n_popped - p0, n_done - d0, busy, out_valid);
        end
    endtask

    task automatic test_reset_mid_sweep();
        int p0;
        push_sweep(1, 1);
        pulse_start(1, 1);
        repeat (8) @(posedge clk);
        #1 reset = 1'b0;
        #1;
        checks++;
        if ({busy, done, rd_en_out, out_valid, out_last} !== '0 || rd_addr_out !== '0 ||
            out_data !== '0 || out_row !== '0 || out_col_submat !== '0) begin
            errors++;
            $display("FAIL reset_mid: busy=%b en=%h valid=%b last=%b addr=%0d row=%0d, required all 0",
                     busy, rd_en_out, out_valid, out_last, rd_addr_out[AW-1:0], out_row);
        end
        sb_q.delete();
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        repeat (5) @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_stale: valid=%b busy=%b after reset, required 0 0", out_valid, busy);
        end
        p0 = n_popped;
        push_sweep(0, 1);
        pulse_start(0, 1);
        wait_done(200, 0, "post_reset");
        checks++;
        if (n_popped - p0 != 32 || sb_q.size() != 0) begin
            errors++;
            $display("FAIL post_reset_sweep: beats=%0d pending=%0d, required 32 0", n_popped - p0, sb_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_single_submat();
        test_full_sweep();
        test_addr_spot();
        test_backpressure();
        test_random_ready();
        test_start_while_busy();
        test_reset_mid_sweep();
        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
